// File: rtl/div_scheduler.sv
// Round-robin scheduler that shares one iterative restoring divider between NREQ requesters.
// One quotient bit is produced per clock. A zero denominator skips the divide loop and returns a saturated result.
module div_scheduler #(
  parameter  int NREQ  = 4,
  parameter  int NUM_W = 32,
  parameter  int DEN_W = 20,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*NUM_W-1:0]   i_num_in,
  input  logic [NREQ*DEN_W-1:0]   i_den_in,
  output logic                    o_busy,
  output logic [IDX_W-1:0]        o_grant_idx,
  output logic [NREQ-1:0]         o_done,
  output logic [NUM_W-1:0]        o_quot,
  output logic [DEN_W-1:0]        o_rem,
  output logic                    o_div_zero
);

  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                       r_state, w_state_nxt;
  logic [NREQ-1:0][NUM_W-1:0]   w_num;
  logic [NREQ-1:0][DEN_W-1:0]   w_den;
  logic [IDX_W-1:0]             r_last, r_grant, w_win;
  logic                         w_any;
  int                           w_t;
  logic [NUM_W-1:0]             r_num, w_num_win;
  logic [DEN_W-1:0]             r_den, w_den_win, r_prem, w_rn;
  logic [DEN_W:0]               w_r;
  logic                         w_ge, w_last_step;
  logic [CNT_W-1:0]             r_cnt;
  logic [NREQ-1:0]              r_done;
  logic [NUM_W-1:0]             r_quot;
  logic [DEN_W-1:0]             r_rem;
  logic                         r_dz;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign w_num[g] = i_num_in[g*NUM_W +: NUM_W];
    assign w_den[g] = i_den_in[g*DEN_W +: DEN_W];
  end

  // First set request after the last winner, wrapping modulo NREQ
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_t   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_t = (int'(r_last) + k) % NREQ;
      if (!w_any && i_req[w_t[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_t[IDX_W-1:0];
      end
    end
  end

  assign w_num_win = w_num[w_win];
  assign w_den_win = w_den[w_win];

  // Restoring step: the shifted partial remainder needs one extra bit before the compare.
  // After a subtract the result is below r_den, so DEN_W bits always hold it.
  assign w_r         = {r_prem, r_num[NUM_W-1]};
  assign w_ge        = (w_r >= {1'b0, r_den});
  assign w_rn        = w_ge ? (w_r[DEN_W-1:0] - r_den) : w_r[DEN_W-1:0];
  assign w_last_step = (r_cnt == CNT_W'(NUM_W-1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = (w_den_win == '0) ? S_DONE : S_CALC;
      S_CALC:  if (w_last_step) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
  end

  // r_num is both the numerator shifter and the quotient accumulator
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last  <= IDX_W'(NREQ-1);
      r_grant <= '0;
      r_num   <= '0;
      r_den   <= '0;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_done  <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_grant <= w_win;
          r_last  <= w_win;
          r_num   <= w_num_win;
          r_den   <= w_den_win;
          r_prem  <= '0;
          r_cnt   <= '0;
          if (w_den_win == '0) begin
            r_quot        <= '1;
            r_rem         <= w_num_win[DEN_W-1:0];
            r_dz          <= 1'b1;
            r_done[w_win] <= 1'b1;
          end
        end
        S_CALC: begin
          r_num  <= {r_num[NUM_W-2:0], w_ge};
          r_prem <= w_rn;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last_step) begin
            r_quot          <= {r_num[NUM_W-2:0], w_ge};
            r_rem           <= w_rn;
            r_dz            <= 1'b0;
            r_done[r_grant] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_grant_idx = r_grant;
  assign o_done      = r_done;
  assign o_quot      = r_quot;
  assign o_rem       = r_rem;
  assign o_div_zero  = r_dz;

endmodule
